// File: rtl/bsr_pkg.sv
// Shared types and helpers for the synchronous boundary-scan register and its host sequencer.
package bsr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAP,
    SHIFT,
    UPD,
    DONE
  } bsr_host_st_t;

  function automatic int bsr_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bsr_host_seq.sv
// Host scan sequencer: runs capture/shift/update without the TAP and owns the shared shift counter.
module bsr_host_seq
  import bsr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = bsr_cnt_w(WIDTH)
) (
  input  logic             iclk,
  input  logic             resetn,
  input  logic             host_req_i,
  input  logic [WIDTH-1:0] host_wdata_i,
  input  logic             sr0_i,
  input  logic             cap_en_i,
  input  logic             shift_en_i,
  output logic             cap_o,
  output logic             shift_o,
  output logic             upd_o,
  output logic             sbit_o,
  output logic [WIDTH-1:0] host_rdata_o,
  output logic             host_ack_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] shift_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] LastShift = CNT_W'(WIDTH - 1);

  bsr_host_st_t     state_q, state_d;
  logic [WIDTH-1:0] wq_q, wq_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wq_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wq_q    <= wq_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter follows the final (host or TAP) enables, so both paths share it.
  always_comb begin
    state_d    = state_q;
    wq_d       = wq_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    cap_o      = 1'b0;
    shift_o    = 1'b0;
    upd_o      = 1'b0;
    sbit_o     = 1'b0;
    host_ack_o = 1'b0;
    busy_o     = (state_q != IDLE);

    if (cap_en_i) begin
      cnt_d = '0;
    end else if (shift_en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (host_req_i) begin
          wq_d    = host_wdata_i;
          state_d = CAP;
        end
      end
      CAP: begin
        cap_o   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_o = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            sbit_o     = wq_q[i];
            rdata_d[i] = sr0_i;
          end
        end
        if (cnt_q == LastShift) begin
          state_d = UPD;
        end
      end
      UPD: begin
        upd_o   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        host_ack_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign host_rdata_o = rdata_q;
  assign shift_cnt_o  = cnt_q;

endmodule

// File: rtl/bsr_sync.sv
// Synchronous boundary-scan register with TAP-decoded enables and a built-in host scan sequencer.
module bsr_sync
  import bsr_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] SAFE_VAL = '0,
  localparam int              CNT_W    = bsr_cnt_w(WIDTH)
) (
  input  logic             iclk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] p_data_in,
  output logic [WIDTH-1:0] p_data_out,
  input  logic             s_data_in,
  output logic             s_data_out,
  input  logic             mode,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             host_req,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] host_rdata,
  output logic             host_ack,
  output logic             busy,
  output logic [CNT_W-1:0] shift_cnt
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] ur_q, ur_d;
  logic             host_cap, host_shift, host_upd, host_sbit;
  logic             tap_ok, cap_en, shift_en, upd_en, serial_in;

  bsr_host_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_host_seq (
    .iclk         (iclk),
    .resetn       (resetn),
    .host_req_i   (host_req),
    .host_wdata_i (host_wdata),
    .sr0_i        (sr_q[0]),
    .cap_en_i     (cap_en),
    .shift_en_i   (shift_en),
    .cap_o        (host_cap),
    .shift_o      (host_shift),
    .upd_o        (host_upd),
    .sbit_o       (host_sbit),
    .host_rdata_o (host_rdata),
    .host_ack_o   (host_ack),
    .busy_o       (busy),
    .shift_cnt_o  (shift_cnt)
  );

  // TAP enables only count in IDLE and lose to a host request arriving in the same cycle.
  always_comb begin
    tap_ok    = !busy && !host_req;
    cap_en    = host_cap   | (tap_ok && capture_dr);
    shift_en  = host_shift | (tap_ok && !capture_dr && shift_dr);
    upd_en    = host_upd   | (tap_ok && !capture_dr && !shift_dr && update_dr);
    serial_in = host_shift ? host_sbit : s_data_in;

    sr_d = sr_q;
    ur_d = ur_q;
    if (cap_en) begin
      sr_d = p_data_in;
    end else if (shift_en) begin
      sr_d = {serial_in, sr_q[WIDTH-1:1]};
    end
    if (upd_en) begin
      ur_d = sr_q;
    end
  end

  always_ff @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      sr_q <= '0;
      ur_q <= SAFE_VAL;
    end else begin
      sr_q <= sr_d;
      ur_q <= ur_d;
    end
  end

  assign s_data_out = sr_q[0];
  assign p_data_out = mode ? ur_q : p_data_in;

endmodule

// File: tb/tb_bsr_sync.sv
// Self-checking bench for bsr_sync: cycle model of TAP and host scans plus hand-computed checks.
module tb_bsr_sync;
  import bsr_pkg::*;

  localparam int               W    = 32;
  localparam int               CW   = bsr_cnt_w(W);
  localparam int               CMAX = (1 << CW) - 1;
  localparam logic [W-1:0]     SAFE = 32'hA5A5_0F0F;

  logic          iclk = 1'b0;
  logic          resetn = 1'b1;
  logic [W-1:0]  p_data_in = '0;
  logic [W-1:0]  p_data_out;
  logic          s_data_in = 1'b0;
  logic          s_data_out;
  logic          mode = 1'b1;
  logic          capture_dr = 1'b0;
  logic          shift_dr = 1'b0;
  logic          update_dr = 1'b0;
  logic          host_req = 1'b0;
  logic [W-1:0]  host_wdata = '0;
  logic [W-1:0]  host_rdata;
  logic          host_ack;
  logic          busy;
  logic [CW-1:0] shift_cnt;

  always #5 iclk = ~iclk;

  bsr_sync #(
    .WIDTH    (W),
    .SAFE_VAL (SAFE)
  ) dut (
    .iclk       (iclk),
    .resetn     (resetn),
    .p_data_in  (p_data_in),
    .p_data_out (p_data_out),
    .s_data_in  (s_data_in),
    .s_data_out (s_data_out),
    .mode       (mode),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .host_req   (host_req),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .busy       (busy),
    .shift_cnt  (shift_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // phase = clock edges since a host request was accepted (0 = no scan in progress)
  typedef struct packed {
    logic [W-1:0] sr;
    logic [W-1:0] ur;
    logic [W-1:0] wq;
    logic [W-1:0] rdata;
    int           cnt;
    int           phase;
  } model_t;

  model_t m;

  function automatic model_t modelStep(model_t c, logic req, logic [W-1:0] wdata, logic [W-1:0] pin,
                                       logic sin, logic cap, logic sh, logic upd);
    model_t n = c;
    if (c.phase == 0) begin
      if (req) begin
        n.wq    = wdata;
        n.phase = 1;
      end else if (cap) begin
        n.sr  = pin;
        n.cnt = 0;
      end else if (sh) begin
        n.sr  = {sin, c.sr[W-1:1]};
        n.cnt = (c.cnt >= CMAX) ? CMAX : c.cnt + 1;
      end else if (upd) begin
        n.ur = c.sr;
      end
    end else begin
      if (c.phase == 1) begin
        n.sr  = pin;
        n.cnt = 0;
      end else if (c.phase <= W + 1) begin
        n.rdata[c.phase-2] = c.sr[0];
        n.sr  = {c.wq[c.phase-2], c.sr[W-1:1]};
        n.cnt = c.phase - 1;
      end else if (c.phase == W + 2) begin
        n.ur = c.sr;
      end
      n.phase = (c.phase == W + 3) ? 0 : c.phase + 1;
    end
    return n;
  endfunction

  always @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      m <= '{sr: '0, ur: SAFE, wq: '0, rdata: '0, cnt: 0, phase: 0};
    end else begin
      m <= modelStep(m, host_req, host_wdata, p_data_in, s_data_in, capture_dr, shift_dr, update_dr);
    end
  end

  always @(negedge iclk) begin
    if (checkEn) begin
      checkOutput("p_data_out", p_data_out, mode ? m.ur : p_data_in);
      checkOutput("s_data_out", {31'b0, s_data_out}, {31'b0, m.sr[0]});
      checkOutput("busy", {31'b0, busy}, {31'b0, m.phase != 0});
      checkOutput("host_ack", {31'b0, host_ack}, {31'b0, m.phase == W + 3});
      checkOutput("shift_cnt", W'(shift_cnt), W'(m.cnt));
      checkOutput("host_rdata", host_rdata, m.rdata);
    end
  end

  task automatic tick();
    @(posedge iclk);
    #2;
  endtask

  // Accepts one host scan and returns the cycle number (1 = cycle after accept) in which ack is high.
  task automatic applyStimulus(input logic [W-1:0] pin, input logic [W-1:0] wdata, output int ackCycle);
    p_data_in  = pin;
    host_wdata = wdata;
    host_req   = 1'b1;
    tick();
    host_req   = 1'b0;
    host_wdata = ~wdata;
    ackCycle   = -1;
    for (int k = 1; k <= 60 && ackCycle < 0; k++) begin
      shift_dr   = (k == 5);
      update_dr  = (k == 6);
      capture_dr = (k == 7);
      s_data_in  = k[0];
      tick();
      if (host_ack) ackCycle = k + 1;
    end
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    capture_dr = 1'b0;
  endtask

  logic [W-1:0] word;
  logic [W-1:0] preload;
  int           ackCyc;
  int           acks;
  int           gap;
  int           lastAck;

  initial begin
    #1 resetn = 1'b0;
    #2 checkEn = 1'b1;
    checkOutput("reset p_data_out", p_data_out, 32'hA5A5_0F0F);
    checkOutput("reset s_data_out", {31'b0, s_data_out}, 32'h0);
    checkOutput("reset busy", {31'b0, busy}, 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // TAP capture then unload LSB-first
    p_data_in  = 32'hDEAD_BEEF;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr   = 1'b1;
    s_data_in  = 1'b0;
    for (int i = 0; i < W; i++) begin
      word[i] = s_data_out;
      tick();
    end
    shift_dr = 1'b0;
    checkOutput("tap unload", word, 32'hDEAD_BEEF);
    checkOutput("tap shift_cnt", W'(shift_cnt), 32'd32);
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    checkOutput("tap update zeros", p_data_out, 32'h0);

    // TAP preload; counter was already 32, so it saturates
    preload  = 32'h1234_5678;
    shift_dr = 1'b1;
    for (int i = 0; i < W; i++) begin
      s_data_in = preload[i];
      tick();
    end
    shift_dr = 1'b0;
    checkOutput("shift_cnt saturate", W'(shift_cnt), 32'd63);
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    checkOutput("preload p_data_out", p_data_out, 32'h1234_5678);

    mode      = 1'b0;
    p_data_in = 32'h0F1E_2D3C;
    tick();
    checkOutput("mode0 pass", p_data_out, 32'h0F1E_2D3C);
    mode = 1'b1;
    tick();

    // Host scan with TAP pulses while busy
    applyStimulus(32'hCAFE_F00D, 32'h0000_FFFF, ackCyc);
    checkOutput("host ack cycle", W'(ackCyc), 32'd35);
    checkOutput("host rdata", host_rdata, 32'hCAFE_F00D);
    tick();
    checkOutput("host busy after", {31'b0, busy}, 32'h0);
    checkOutput("host p_data_out", p_data_out, 32'h0000_FFFF);

    // Capture and shift together: capture wins
    p_data_in  = 32'h0000_0003;
    capture_dr = 1'b1;
    shift_dr   = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    checkOutput("cap+shift cnt", W'(shift_cnt), 32'd0);
    checkOutput("cap+shift sdo", {31'b0, s_data_out}, 32'h1);

    // Reset in the middle of the shift phase
    host_wdata = 32'h5555_AAAA;
    host_req   = 1'b1;
    tick();
    host_req = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    resetn = 1'b0;
    #1;
    checkOutput("midreset busy", {31'b0, busy}, 32'h0);
    checkOutput("midreset ur", p_data_out, 32'hA5A5_0F0F);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    applyStimulus(32'h0BAD_CAFE, 32'hF0F0_1234, ackCyc);
    checkOutput("post-reset ack cycle", W'(ackCyc), 32'd35);
    checkOutput("post-reset rdata", host_rdata, 32'h0BAD_CAFE);
    tick();
    checkOutput("post-reset p_data_out", p_data_out, 32'hF0F0_1234);

    // Back-to-back scans with host_req held high
    p_data_in  = 32'h1357_9BDF;
    host_wdata = 32'h2468_ACE0;
    host_req   = 1'b1;
    acks    = 0;
    lastAck = 0;
    gap     = 0;
    for (int k = 1; k <= 120 && acks < 2; k++) begin
      tick();
      if (host_ack) begin
        acks++;
        if (acks == 2) gap = k - lastAck;
        lastAck = k;
      end
    end
    host_req = 1'b0;
    checkOutput("b2b ack count", W'(acks), 32'd2);
    checkOutput("b2b ack gap", W'(gap), 32'd36);
    tick();
    checkOutput("b2b p_data_out", p_data_out, 32'h2468_ACE0);
    tick();

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
